iob_pcie_chnl_ctrl: RTL and testbench
=====================================

// Module: iob_pcie_chnl_ctrl
// PURPOSE
//  Single-clock RIFFA-style PCIe channel controller: FSM-driven RX and TX transaction handshakes, word
//  counting and FWFT FIFO buffering at PCI_DATA_W. Sits between the PCIe channel interface and the
//  CPU-side register/DMA logic of iob_pcie; replaces software-sequenced ack/valid bits with hardware.
// PARAMETERS
//  PCI_DATA_W   64  channel data width; 32, 64 or 128 (multiple of 32)
//  FIFO_ADDR_W  5   log2 depth of each of the RX and TX FIFOs
//  LEN_W        32  width of transaction length fields (units of 32-bit words)
// PORTS
//  clk                   in   1            system clock
//  rst_n                 in   1            reset, asynchronous, active-low
//  soft_clr_i            in   1            synchronous flush: FSMs to IDLE, FIFOs emptied
//  chnl_rx_i             in   1            RX transaction pending
//  chnl_rx_last_i        in   1            RX transaction is last of sequence
//  chnl_rx_len_i         in   LEN_W        RX length, 32-bit words
//  chnl_rx_data_i        in   PCI_DATA_W   RX data beat
//  chnl_rx_data_valid_i  in   1            RX beat valid
//  chnl_rx_data_ren_o    out  1            RX beat consumed when high with valid
//  chnl_rx_ack_o         out  1            RX transaction acknowledge pulse
//  chnl_tx_o             out  1            TX transaction active
//  chnl_tx_last_o        out  1            TX transaction is last of sequence
//  chnl_tx_len_o         out  LEN_W        TX length, 32-bit words
//  chnl_tx_data_o        out  PCI_DATA_W   TX data beat (TX FIFO head)
//  chnl_tx_data_valid_o  out  1            TX beat valid
//  chnl_tx_data_ren_i    in   1            TX beat consumed when high with valid
//  chnl_tx_ack_i         in   1            TX transaction acknowledged
//  rx_data_o / rx_empty_o / rx_ren_i        out/out/in  PCI_DATA_W/1/1  CPU pop port, FWFT
//  rx_level_o            out  FIFO_ADDR_W+1  RX FIFO occupancy
//  rx_len_o / rx_last_o  out  LEN_W/1      latched length/last of current RX transaction
//  rx_done_o             out  1            sticky: RX transaction finished; cleared by rx_done_clr_i
//  rx_done_clr_i         in   1            clears rx_done_o
//  tx_data_i / tx_wen_i / tx_full_o         in/in/out  PCI_DATA_W/1/1  CPU push port
//  tx_level_o            out  FIFO_ADDR_W+1  TX FIFO occupancy
//  tx_start_i / tx_len_i / tx_last_i        in  1/LEN_W/1  start TX transaction (pulse)
//  tx_busy_o / tx_done_o out  1/1          TX FSM not idle / 1-cycle pulse on TX completion
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0, FIFOs empty, both FSMs IDLE, rx_done_o 0. soft_clr_i: same, sync.
//  Beats: BEATS = ceil(len / (PCI_DATA_W/32)), computed at latch time, LEN_W bits; partial last beat counts 1.
//  FIFOs: sync, FWFT; push while full ignored, pop while empty ignored; simultaneous push+pop keeps level.
//  RX FSM:
//   R_IDLE: chnl_rx_i=1 -> latch len/last, compute BEATS -> R_ACK.
//   R_ACK: chnl_rx_ack_o=1 exactly one cycle; BEATS=0 -> R_DONE, else R_DATA.
//   R_DATA: chnl_rx_data_ren_o = ~rx_full (registered full; no ren on a full FIFO even with same-cycle pop).
//    Beat accepted when valid & ren -> push FIFO, count++. Count reaches BEATS -> R_DONE.
//    chnl_rx_i low before BEATS reached -> R_DONE (short transfer; accepted data kept).
//   R_DONE: rx_done_o set (sticky); wait chnl_rx_i=0 -> R_IDLE. rx_done_clr_i same cycle as set: set wins.
//  TX FSM:
//   T_IDLE: tx_start_i -> latch len/last, compute BEATS -> T_REQ; tx_start_i while busy ignored.
//   T_REQ: chnl_tx_o=1, len/last driven; wait chnl_tx_ack_i -> T_DATA (BEATS=0 -> T_IDLE with tx_done_o).
//   T_DATA: chnl_tx_data_valid_o = ~tx_empty; beat consumed on valid & ren -> pop, count++.
//    Last beat consumed -> T_IDLE, chnl_tx_o drops next cycle, tx_done_o pulses 1 cycle.
//   chnl_tx_data_valid_o is 0 outside T_DATA even when TX FIFO non-empty.
//  tx_busy_o = state != T_IDLE. RX and TX FSMs independent; may run concurrently.
//  Latency: RX beat visible on rx_data_o 1 cycle after accept; TX FIFO write visible on chnl_tx_data_o next cycle.
// TESTING
//  PCI_DATA_W=64, rx len=8 words, valid every cycle -> one ack pulse, 4 beats in FIFO, rx_done_o=1.
//  rx len=7 -> BEATS=4; rx len=0 -> ack pulse, no ren, rx_done_o immediately.
//  RX 40 beats, FIFO depth 32, CPU not popping -> ren low at level 32, no data lost; popping resumes flow.
//  Push 4 beats, tx_start len=8 -> chnl_tx_o, data only after ack, random ren, tx_done_o after 4th beat.
//  tx_start during T_DATA ignored; soft_clr_i mid-RX and async rst_n mid-TX -> all outputs 0, levels 0.

Source files
------------

// File: rtl/iob_pcie_chnl_ctrl.sv
// ----------------------------------------------------------------------------
// iob_pcie_chnl_ctrl
//
// Purpose
//   RIFFA-style PCIe channel controller. Two independent FSMs run the RX and
//   TX channel handshakes in hardware. Each FSM counts data beats of
//   PCI_DATA_W bits. A first-word-fall-through FIFO on each side buffers
//   data towards the CPU-side register/DMA logic.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   soft_clr_i                   synchronous flush of both FSMs and FIFOs
//   chnl_rx_*                    PCIe RX channel (pending/last/len/data/ack)
//   chnl_tx_*                    PCIe TX channel (active/last/len/data/ack)
//   rx_data_o/rx_empty_o/rx_ren_i/rx_level_o   CPU pop port of the RX FIFO
//   rx_len_o/rx_last_o/rx_done_o/rx_done_clr_i RX transaction status
//   tx_data_i/tx_wen_i/tx_full_o/tx_level_o    CPU push port of the TX FIFO
//   tx_start_i/tx_len_i/tx_last_i              TX transaction request
//   tx_busy_o/tx_done_o                        TX transaction status
// ----------------------------------------------------------------------------

// Synchronous FWFT FIFO. The head word is presented combinationally, so a
// write becomes visible on data_o in the cycle after it is accepted. data_o
// is forced to zero while the FIFO is empty so that stale storage never
// shows up on the outputs.
module iob_pcie_chnl_fifo #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ren_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              push;
    logic              pop;

    assign empty_o = (level_q == '0);
    assign full_o  = level_q[ADDR_W];
    assign level_o = level_q;
    assign push    = wen_i & ~full_o;
    assign pop     = ren_i & ~empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      level_q <= level_q + (ADDR_W+1)'(1);
            else if (pop && !push) level_q <= level_q - (ADDR_W+1)'(1);
        end
    end
endmodule

module iob_pcie_chnl_ctrl #(
    parameter int PCI_DATA_W  = 64,
    parameter int FIFO_ADDR_W = 5,
    parameter int LEN_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_clr_i,
    input  logic                  chnl_rx_i,
    input  logic                  chnl_rx_last_i,
    input  logic [LEN_W-1:0]      chnl_rx_len_i,
    input  logic [PCI_DATA_W-1:0] chnl_rx_data_i,
    input  logic                  chnl_rx_data_valid_i,
    output logic                  chnl_rx_data_ren_o,
    output logic                  chnl_rx_ack_o,
    output logic                  chnl_tx_o,
    output logic                  chnl_tx_last_o,
    output logic [LEN_W-1:0]      chnl_tx_len_o,
    output logic [PCI_DATA_W-1:0] chnl_tx_data_o,
    output logic                  chnl_tx_data_valid_o,
    input  logic                  chnl_tx_data_ren_i,
    input  logic                  chnl_tx_ack_i,
    output logic [PCI_DATA_W-1:0] rx_data_o,
    output logic                  rx_empty_o,
    input  logic                  rx_ren_i,
    output logic [FIFO_ADDR_W:0]  rx_level_o,
    output logic [LEN_W-1:0]      rx_len_o,
    output logic                  rx_last_o,
    output logic                  rx_done_o,
    input  logic                  rx_done_clr_i,
    input  logic [PCI_DATA_W-1:0] tx_data_i,
    input  logic                  tx_wen_i,
    output logic                  tx_full_o,
    output logic [FIFO_ADDR_W:0]  tx_level_o,
    input  logic                  tx_start_i,
    input  logic [LEN_W-1:0]      tx_len_i,
    input  logic                  tx_last_i,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);
    // 32-bit words per beat; always a power of two (1, 2 or 4).
    localparam int WPB = PCI_DATA_W / 32;
    localparam int SH  = $clog2(WPB);

    // Beats needed for a length in 32-bit words, rounding a partial last
    // beat up. Shift-and-carry form avoids overflow near the top of LEN_W.
    function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] mask;
        mask = LEN_W'(WPB - 1);
        return (len >> SH) + LEN_W'(|(len & mask));
    endfunction

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA, R_DONE} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_DATA} tx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [LEN_W-1:0] rx_len_q, rx_len_d;
    logic             rx_last_q, rx_last_d;
    logic [LEN_W-1:0] rx_beats_q, rx_beats_d;
    logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_done_q, rx_done_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [LEN_W-1:0] tx_len_q, tx_len_d;
    logic             tx_last_q, tx_last_d;
    logic [LEN_W-1:0] tx_beats_q, tx_beats_d;
    logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_done_q, tx_done_d;

    logic rx_push;
    logic rx_full;
    logic tx_pop;
    logic tx_empty;

    // ---------------- FIFOs ----------------
    iob_pcie_chnl_fifo #(.DATA_W(PCI_DATA_W), .ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (soft_clr_i),
        .wen_i   (rx_push),
        .data_i  (chnl_rx_data_i),
        .ren_i   (rx_ren_i),
        .data_o  (rx_data_o),
        .empty_o (rx_empty_o),
        .full_o  (rx_full),
        .level_o (rx_level_o)
    );

    iob_pcie_chnl_fifo #(.DATA_W(PCI_DATA_W), .ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (soft_clr_i),
        .wen_i   (tx_wen_i),
        .data_i  (tx_data_i),
        .ren_i   (tx_pop),
        .data_o  (chnl_tx_data_o),
        .empty_o (tx_empty),
        .full_o  (tx_full_o),
        .level_o (tx_level_o)
    );

    // ---------------- RX FSM ----------------
    always_comb begin
        rx_state_d         = rx_state_q;
        rx_len_d           = rx_len_q;
        rx_last_d          = rx_last_q;
        rx_beats_d         = rx_beats_q;
        rx_cnt_d           = rx_cnt_q;
        rx_done_d          = rx_done_q;
        chnl_rx_ack_o      = 1'b0;
        chnl_rx_data_ren_o = 1'b0;
        rx_push            = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (chnl_rx_i) begin
                    rx_len_d   = chnl_rx_len_i;
                    rx_last_d  = chnl_rx_last_i;
                    rx_beats_d = beats_of(chnl_rx_len_i);
                    rx_cnt_d   = '0;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK: begin
                chnl_rx_ack_o = 1'b1;
                rx_state_d    = (rx_beats_q == '0) ? R_DONE : R_DATA;
            end
            R_DATA: begin
                // Registered full only: a same-cycle CPU pop does not open
                // the door, keeping ren free of a combinational path from rx_ren_i.
                chnl_rx_data_ren_o = ~rx_full;
                if (chnl_rx_data_valid_i && !rx_full) begin
                    rx_push  = 1'b1;
                    rx_cnt_d = rx_cnt_q + LEN_W'(1);
                    if (rx_cnt_q + LEN_W'(1) == rx_beats_q) rx_state_d = R_DONE;
                end
                // Sender withdrew early: keep what arrived and finish.
                if (!chnl_rx_i) rx_state_d = R_DONE;
            end
            R_DONE: begin
                if (!chnl_rx_i) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
        // Sticky done flag is set on entry to R_DONE; set beats clear.
        if (rx_state_d == R_DONE && rx_state_q != R_DONE) rx_done_d = 1'b1;
        else if (rx_done_clr_i)                         rx_done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            rx_len_q   <= '0;
            rx_last_q  <= 1'b0;
            rx_beats_q <= '0;
            rx_cnt_q   <= '0;
            rx_done_q  <= 1'b0;
        end else if (soft_clr_i) begin
            rx_state_q <= R_IDLE;
            rx_len_q   <= '0;
            rx_last_q  <= 1'b0;
            rx_beats_q <= '0;
            rx_cnt_q   <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_last_q  <= rx_last_d;
            rx_beats_q <= rx_beats_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign rx_len_o  = rx_len_q;
    assign rx_last_o = rx_last_q;
    assign rx_done_o = rx_done_q;

    // ---------------- TX FSM ----------------
    always_comb begin
        tx_state_d           = tx_state_q;
        tx_len_d             = tx_len_q;
        tx_last_d            = tx_last_q;
        tx_beats_d           = tx_beats_q;
        tx_cnt_d             = tx_cnt_q;
        tx_done_d            = 1'b0;
        tx_pop               = 1'b0;
        chnl_tx_o            = 1'b0;
        chnl_tx_data_valid_o = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (tx_start_i) begin
                    tx_len_d   = tx_len_i;
                    tx_last_d  = tx_last_i;
                    tx_beats_d = beats_of(tx_len_i);
                    tx_state_d = T_REQ;
                end
            end
            T_REQ: begin
                chnl_tx_o = 1'b1;
                if (chnl_tx_ack_i) begin
                    tx_cnt_d = '0;
                    if (tx_beats_q == '0) begin
                        tx_state_d = T_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_state_d = T_DATA;
                    end
                end
            end
            T_DATA: begin
                chnl_tx_o            = 1'b1;
                chnl_tx_data_valid_o = ~tx_empty;
                if (!tx_empty && chnl_tx_data_ren_i) begin
                    tx_pop   = 1'b1;
                    tx_cnt_d = tx_cnt_q + LEN_W'(1);
                    if (tx_cnt_q + LEN_W'(1) == tx_beats_q) begin
                        tx_state_d = T_IDLE;
                        tx_done_d  = 1'b1;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            tx_len_q   <= '0;
            tx_last_q  <= 1'b0;
            tx_beats_q <= '0;
            tx_cnt_q   <= '0;
            tx_done_q  <= 1'b0;
        end else if (soft_clr_i) begin
            tx_state_q <= T_IDLE;
            tx_len_q   <= '0;
            tx_last_q  <= 1'b0;
            tx_beats_q <= '0;
            tx_cnt_q   <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_len_q   <= tx_len_d;
            tx_last_q  <= tx_last_d;
            tx_beats_q <= tx_beats_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Length/last are only presented while the transaction is on the channel.
    assign chnl_tx_len_o  = chnl_tx_o ? tx_len_q : '0;
    assign chnl_tx_last_o = chnl_tx_o & tx_last_q;
    assign tx_busy_o      = (tx_state_q != T_IDLE);
    assign tx_done_o      = tx_done_q;
endmodule

// File: tb/tb_iob_pcie_chnl_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iob_pcie_chnl_ctrl
//
// Self-checking bench for iob_pcie_chnl_ctrl (PCI_DATA_W=64, depth 32).
// The reference model keeps the FIFO contents as queues and derives the
// beat count of a transaction as ceil(len / words-per-beat).
// ----------------------------------------------------------------------------
module tb_iob_pcie_chnl_ctrl;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int LW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int WPB   = DW / 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_clr_i = 1'b0;
    logic          chnl_rx_i = 1'b0;
    logic          chnl_rx_last_i = 1'b0;
    logic [LW-1:0] chnl_rx_len_i = '0;
    logic [DW-1:0] chnl_rx_data_i = '0;
    logic          chnl_rx_data_valid_i = 1'b0;
    logic          chnl_rx_data_ren_o;
    logic          chnl_rx_ack_o;
    logic          chnl_tx_o;
    logic          chnl_tx_last_o;
    logic [LW-1:0] chnl_tx_len_o;
    logic [DW-1:0] chnl_tx_data_o;
    logic          chnl_tx_data_valid_o;
    logic          chnl_tx_data_ren_i = 1'b0;
    logic          chnl_tx_ack_i = 1'b0;
    logic [DW-1:0] rx_data_o;
    logic          rx_empty_o;
    logic          rx_ren_i = 1'b0;
    logic [AW:0]   rx_level_o;
    logic [LW-1:0] rx_len_o;
    logic          rx_last_o;
    logic          rx_done_o;
    logic          rx_done_clr_i = 1'b0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_wen_i = 1'b0;
    logic          tx_full_o;
    logic [AW:0]   tx_level_o;
    logic          tx_start_i = 1'b0;
    logic [LW-1:0] tx_len_i = '0;
    logic          tx_last_i = 1'b0;
    logic          tx_busy_o;
    logic          tx_done_o;

    always #5 clk = ~clk;

    iob_pcie_chnl_ctrl #(.PCI_DATA_W(DW), .FIFO_ADDR_W(AW), .LEN_W(LW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .soft_clr_i           (soft_clr_i),
        .chnl_rx_i            (chnl_rx_i),
        .chnl_rx_last_i       (chnl_rx_last_i),
        .chnl_rx_len_i        (chnl_rx_len_i),
        .chnl_rx_data_i       (chnl_rx_data_i),
        .chnl_rx_data_valid_i (chnl_rx_data_valid_i),
        .chnl_rx_data_ren_o   (chnl_rx_data_ren_o),
        .chnl_rx_ack_o        (chnl_rx_ack_o),
        .chnl_tx_o            (chnl_tx_o),
        .chnl_tx_last_o       (chnl_tx_last_o),
        .chnl_tx_len_o        (chnl_tx_len_o),
        .chnl_tx_data_o       (chnl_tx_data_o),
        .chnl_tx_data_valid_o (chnl_tx_data_valid_o),
        .chnl_tx_data_ren_i   (chnl_tx_data_ren_i),
        .chnl_tx_ack_i        (chnl_tx_ack_i),
        .rx_data_o            (rx_data_o),
        .rx_empty_o           (rx_empty_o),
        .rx_ren_i             (rx_ren_i),
        .rx_level_o           (rx_level_o),
        .rx_len_o             (rx_len_o),
        .rx_last_o            (rx_last_o),
        .rx_done_o            (rx_done_o),
        .rx_done_clr_i        (rx_done_clr_i),
        .tx_data_i            (tx_data_i),
        .tx_wen_i             (tx_wen_i),
        .tx_full_o            (tx_full_o),
        .tx_level_o           (tx_level_o),
        .tx_start_i           (tx_start_i),
        .tx_len_i             (tx_len_i),
        .tx_last_i            (tx_last_i),
        .tx_busy_o            (tx_busy_o),
        .tx_done_o            (tx_done_o)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] rq[$];
    logic [DW-1:0] tq[$];
    logic [DW-1:0] seq_val;

    typedef struct {
        int len;
        int exp_beats;
        int exp_level;
    } rx_vec_t;

    function automatic int beats_model(input int len);
        return (len + WPB - 1) / WPB;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rx_ack"},   64'(chnl_rx_ack_o), 64'(0));
        chk({tag, "_rx_ren"},   64'(chnl_rx_data_ren_o), 64'(0));
        chk({tag, "_tx"},       64'(chnl_tx_o), 64'(0));
        chk({tag, "_tx_last"},  64'(chnl_tx_last_o), 64'(0));
        chk({tag, "_tx_len"},   64'(chnl_tx_len_o), 64'(0));
        chk({tag, "_tx_data"},  64'(chnl_tx_data_o), 64'(0));
        chk({tag, "_tx_valid"}, 64'(chnl_tx_data_valid_o), 64'(0));
        chk({tag, "_rx_data"},  64'(rx_data_o), 64'(0));
        chk({tag, "_rx_empty"}, 64'(rx_empty_o), 64'(1));
        chk({tag, "_rx_level"}, 64'(rx_level_o), 64'(0));
        chk({tag, "_rx_len"},   64'(rx_len_o), 64'(0));
        chk({tag, "_rx_last"},  64'(rx_last_o), 64'(0));
        chk({tag, "_rx_done"},  64'(rx_done_o), 64'(0));
        chk({tag, "_tx_full"},  64'(tx_full_o), 64'(0));
        chk({tag, "_tx_level"}, 64'(tx_level_o), 64'(0));
        chk({tag, "_tx_busy"},  64'(tx_busy_o), 64'(0));
        chk({tag, "_tx_done"},  64'(tx_done_o), 64'(0));
    endtask

    // One RX transaction. abort_at >= 0 withdraws chnl_rx_i once that many
    // beats have been accepted. CPU pops start after pop_start cycles.
    task automatic rx_xfer(input int len, input int valid_pct, input int pop_pct,
                           input int pop_start, input int abort_at, input int exp_beats,
                           output int acc);
        int   acks;
        int   cycles;
        int   maxlvl;
        bit   done_seen;
        bit   pop_eff;
        bit   acc_eff;
        logic lastv;
        acc = 0; acks = 0; cycles = 0; maxlvl = 0; done_seen = 0;
        lastv = 1'($urandom);
        chnl_rx_i = 1'b1; chnl_rx_last_i = lastv; chnl_rx_len_i = LW'(len);
        while (!done_seen && cycles < 400) begin
            chnl_rx_data_valid_i = ($urandom_range(99) < valid_pct);
            chnl_rx_data_i       = seq_val;
            rx_ren_i             = (cycles >= pop_start) && ($urandom_range(99) < pop_pct);
            if (abort_at >= 0 && acc == abort_at) begin
                chnl_rx_i = 1'b0; chnl_rx_data_valid_i = 1'b0;
            end
            settle();
            chk("rx_level", 64'(rx_level_o), 64'(rq.size()));
            chk("rx_empty", 64'(rx_empty_o), 64'(rq.size() == 0));
            if (rq.size() > maxlvl) maxlvl = rq.size();
            if (chnl_rx_ack_o) acks++;
            if (chnl_rx_data_ren_o) chk("rx_ren_while_full", 64'(rq.size() < DEPTH), 64'(1));
            pop_eff = rx_ren_i && (rq.size() > 0);
            acc_eff = chnl_rx_data_ren_o && chnl_rx_data_valid_i;
            if (pop_eff) begin
                chk("rx_data", rx_data_o, rq[0]);
                void'(rq.pop_front());
            end
            if (acc_eff) begin
                chk("rx_extra_beat", 64'(acc < exp_beats), 64'(1));
                rq.push_back(seq_val);
                seq_val = {$urandom, $urandom};
                acc++;
            end
            if (rx_done_o) done_seen = 1'b1;
            cyc();
            cycles++;
        end
        chnl_rx_i = 1'b0; chnl_rx_data_valid_i = 1'b0; rx_ren_i = 1'b0;
        chk("rx_done_timeout", 64'(done_seen), 64'(1));
        chk("rx_ack_pulses", 64'(acks), 64'(1));
        chk("rx_beats", 64'(acc), 64'(exp_beats));
        if (pop_start > 0 && pop_pct > 0 && exp_beats > DEPTH)
            chk("rx_bp_full_reached", 64'(maxlvl), 64'(DEPTH));
        settle();
        chk("rx_done_sticky", 64'(rx_done_o), 64'(1));
        chk("rx_len_o", 64'(rx_len_o), 64'(len));
        chk("rx_last_o", 64'(rx_last_o), 64'(lastv));
        cyc();
        rx_done_clr_i = 1'b1;
        cyc();
        rx_done_clr_i = 1'b0;
        settle();
        chk("rx_done_clr", 64'(rx_done_o), 64'(0));
        $display("rx xfer: len=%0d beats=%0d level=%0d max_level=%0d", len, acc, rq.size(), maxlvl);
    endtask

    task automatic rx_drain();
        int guard;
        guard = 0;
        while (rq.size() > 0 && guard < 100) begin
            rx_ren_i = 1'b1;
            settle();
            chk("rx_drain_data", rx_data_o, rq[0]);
            void'(rq.pop_front());
            cyc();
            guard++;
        end
        rx_ren_i = 1'b0;
        settle();
        chk("rx_drain_empty", 64'(rx_empty_o), 64'(1));
        cyc();
    endtask

    task automatic tx_push(input int n);
        for (int i = 0; i < n; i++) begin
            tx_data_i = {$urandom, $urandom};
            tx_wen_i  = 1'b1;
            settle();
            chk("tx_level", 64'(tx_level_o), 64'(tq.size()));
            chk("tx_full", 64'(tx_full_o), 64'(tq.size() == DEPTH));
            if (tq.size() < DEPTH) tq.push_back(tx_data_i);
            cyc();
        end
        tx_wen_i = 1'b0;
    endtask

    // One TX transaction; restart pulses tx_start_i during the data phase.
    task automatic tx_xfer(input int len, input int ren_pct, input int ack_delay, input bit restart);
        int   beats;
        int   cnt;
        int   cycles;
        logic lastv;
        beats = beats_model(len);
        lastv = 1'($urandom);
        tx_start_i = 1'b1; tx_len_i = LW'(len); tx_last_i = lastv;
        settle();
        chk("tx_idle_before_start", 64'(chnl_tx_o), 64'(0));
        cyc();
        tx_start_i = 1'b0; tx_len_i = '0; tx_last_i = 1'b0;
        for (int d = 0; d <= ack_delay; d++) begin
            chnl_tx_ack_i = (d == ack_delay);
            settle();
            chk("tx_req", 64'(chnl_tx_o), 64'(1));
            chk("tx_req_len", 64'(chnl_tx_len_o), 64'(len));
            chk("tx_req_last", 64'(chnl_tx_last_o), 64'(lastv));
            chk("tx_valid_before_ack", 64'(chnl_tx_data_valid_o), 64'(0));
            chk("tx_busy", 64'(tx_busy_o), 64'(1));
            cyc();
        end
        chnl_tx_ack_i = 1'b0;
        cnt = 0; cycles = 0;
        while (cnt < beats && cycles < 300) begin
            chnl_tx_data_ren_i = ($urandom_range(99) < ren_pct);
            tx_start_i = restart && (cycles == 0);
            tx_len_i   = tx_start_i ? LW'(len + 6) : '0;
            settle();
            chk("tx_active", 64'(chnl_tx_o), 64'(1));
            chk("tx_len_hold", 64'(chnl_tx_len_o), 64'(len));
            chk("tx_valid", 64'(chnl_tx_data_valid_o), 64'(tq.size() > 0));
            if (tq.size() > 0) chk("tx_data", chnl_tx_data_o, tq[0]);
            if (tq.size() > 0 && chnl_tx_data_ren_i) begin
                void'(tq.pop_front());
                cnt++;
            end
            cyc();
            cycles++;
        end
        tx_start_i = 1'b0; tx_len_i = '0; chnl_tx_data_ren_i = 1'b0;
        chk("tx_beats", 64'(cnt), 64'(beats));
        settle();
        chk("tx_end_active", 64'(chnl_tx_o), 64'(0));
        chk("tx_done_pulse", 64'(tx_done_o), 64'(1));
        chk("tx_end_busy", 64'(tx_busy_o), 64'(0));
        chk("tx_end_level", 64'(tx_level_o), 64'(tq.size()));
        cyc();
        settle();
        chk("tx_done_one_cycle", 64'(tx_done_o), 64'(0));
        cyc();
        $display("tx xfer: len=%0d beats=%0d left_in_fifo=%0d", len, cnt, tq.size());
    endtask

    rx_vec_t vt[7];
    int      acc;
    int      len;

    initial begin
        seq_val = 64'h1111_0000_0000_0001;
        vt[0] = '{8, 4, 4};
        vt[1] = '{7, 4, 4};
        vt[2] = '{0, 0, 0};
        vt[3] = '{1, 1, 1};
        vt[4] = '{2, 1, 1};
        vt[5] = '{3, 2, 2};
        vt[6] = '{64, 32, 32};

        #3;
        chk_idle("reset");
        #10;
        rst_n = 1'b1;
        cyc();

        // Table: beat rounding and level with no CPU pops, valid every cycle.
        for (int i = 0; i < 7; i++) begin
            rx_xfer(vt[i].len, 100, 0, 0, -1, vt[i].exp_beats, acc);
            chk("rx_tbl_level", 64'(rx_level_o), 64'(vt[i].exp_level));
            rx_drain();
        end

        // Backpressure: 40 beats into a 32-deep FIFO, CPU pops late.
        rx_xfer(80, 100, 70, 50, -1, 40, acc);
        rx_drain();

        // Short transfer: sender withdraws after 3 of 10 beats.
        rx_xfer(20, 100, 0, 0, 3, 3, acc);
        chk("rx_short_level", 64'(rx_level_o), 64'(3));
        rx_drain();

        // Randomised RX transactions.
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(0, 50);
            rx_xfer(len, 70, 50, 0, -1, beats_model(len), acc);
            rx_drain();
        end

        // TX: 4 beats, len 8, delayed ack, random ren, restart ignored.
        tx_push(4);
        tx_xfer(8, 50, 3, 1'b1);
        tx_xfer(0, 100, 1, 1'b0);
        tx_push(4);
        tx_xfer(7, 60, 0, 1'b0);

        // Randomised TX transactions.
        for (int i = 0; i < 6; i++) begin
            tx_push($urandom_range(0, 10));
            len = $urandom_range(0, 2 * tq.size());
            tx_xfer(len, 60, $urandom_range(0, 3), 1'($urandom));
        end

        // Soft clear in the middle of an RX transaction.
        tx_push(3);
        chnl_rx_i = 1'b1; chnl_rx_len_i = LW'(16); chnl_rx_data_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        settle();
        chk("soft_clr_pre_level", 64'(rx_level_o > 0), 64'(1));
        soft_clr_i = 1'b1; chnl_rx_i = 1'b0; chnl_rx_data_valid_i = 1'b0;
        cyc();
        soft_clr_i = 1'b0;
        settle();
        chk_idle("soft_clr");
        rq.delete(); tq.delete();
        $display("soft clear during rx transaction");
        cyc();

        // Asynchronous reset in the middle of a TX transaction.
        tx_push(6);
        tx_start_i = 1'b1; tx_len_i = LW'(12);
        cyc();
        tx_start_i = 1'b0; tx_len_i = '0; chnl_tx_ack_i = 1'b1;
        cyc();
        chnl_tx_ack_i = 1'b0; chnl_tx_data_ren_i = 1'b1;
        cyc();
        cyc();
        chnl_tx_data_ren_i = 1'b0;
        settle();
        chk("async_pre_tx", 64'(chnl_tx_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        tq.delete();
        #3;
        rst_n = 1'b1;
        cyc();
        settle();
        chk_idle("after_rst");
        $display("async reset during tx transaction");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end
endmodule
